// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down modulo counter family.
//   CNT_DN / CNT_UP : direction encoding for the 'up' input.
//   clamp_val       : limits a value to a maximum; used to keep parallel
//                     loads inside the legal count range. Operates on a
//                     32-bit container so it can serve any counter width.
package cnt_pkg;

    localparam logic CNT_DN = 1'b0;
    localparam logic CNT_UP = 1'b1;

    function automatic logic [31:0] clamp_val(input logic [31:0] val,
                                              input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-value unit for a modulo up/down counter.
// Ports:
//   count   in  N  current count
//   up      in  1  direction (CNT_UP / CNT_DN)
//   next    out N  value the counter moves to when enabled (modulo wrap)
//   at_term out 1  count sits at the terminal value for this direction
//                  (MAX_VAL when counting up, 0 when counting down)
module cnt_next_val
    import cnt_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAX_VAL = 2**N - 1
) (
    input  logic [N-1:0] count,
    input  logic         up,
    output logic [N-1:0] next,
    output logic         at_term
);

    localparam logic [N-1:0] MAX_N = N'(MAX_VAL);

    always_comb begin
        next    = '0;
        at_term = 1'b0;
        if (up == CNT_UP) begin
            at_term = (count == MAX_N);
            // Compare before incrementing so the sum never needs N+1 bits;
            // a corrupted out-of-range value also recovers to 0 here.
            next    = (count >= MAX_N) ? '0 : count + 1'b1;
        end else begin
            at_term = (count == '0);
            next    = (count == '0) ? MAX_N : count - 1'b1;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Registered N-bit up/down counter with programmable modulus 0..MAX_VAL.
// Priority per edge: clr > load > en > hold.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset (count=0, wrap=0)
//   clr      in  1  synchronous clear to 0
//   load     in  1  synchronous load of load_val (clamped to MAX_VAL)
//   load_val in  N  parallel load value
//   en       in  1  count enable (connect to lower stage's tc to cascade)
//   up       in  1  1 = count up, 0 = count down
//   count    out N  registered count
//   tc       out 1  combinational terminal count, gated by en
//   wrap     out 1  one-cycle pulse after a wrap (or saturated hold)
// Build option: define UPDOWN_CNT_SAT_EN to saturate at the range ends
// instead of wrapping; tc behaviour is identical in both builds.
module updown_mod_counter
    import cnt_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAX_VAL = 2**N - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap
);

    logic [N-1:0] next;
    logic         at_term;
    logic [N-1:0] load_clamped;

    cnt_next_val #(
        .N       (N),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count   (count),
        .up      (up),
        .next    (next),
        .at_term (at_term)
    );

    assign load_clamped = N'(clamp_val(32'(load_val), 32'(MAX_VAL)));

    // Unregistered so a chain of counters ripples within a single cycle.
    assign tc = en & at_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
`ifdef UPDOWN_CNT_SAT_EN
            // Boundary reached: hold, but still flag the attempt.
            count <= at_term ? count : next;
`else
            count <= next;
`endif
            wrap  <= at_term;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (N=4, MAX_VAL=9) plus
// a two-stage mod-60 cascade (MAX_VAL=9 and MAX_VAL=5).
module tb_updown_mod_counter;

`ifdef UPDOWN_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc, wrap;

    logic       c_en;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;
    logic       zero1 = 1'b0;
    logic       one1  = 1'b1;
    logic [3:0] zero4 = 4'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.N(4), .MAX_VAL(9)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(count), .tc(tc), .wrap(wrap)
    );

    updown_mod_counter #(.N(4), .MAX_VAL(9)) u_lo (
        .clk(clk), .rst_n(rst_n), .clr(zero1), .load(zero1), .load_val(zero4),
        .en(c_en), .up(one1), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap)
    );

    updown_mod_counter #(.N(4), .MAX_VAL(5)) u_hi (
        .clk(clk), .rst_n(rst_n), .clr(zero1), .load(zero1), .load_val(zero4),
        .en(lo_tc), .up(one1), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap)
    );

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic       etc;    // tc expected before the edge
        logic [3:0] ecnt;   // count expected after the edge
        logic       ewrap;  // wrap expected after the edge
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u);
        clr = c; load = l; load_val = lv; en = e; up = u;
    endtask

    // Inputs change on the falling edge; results sampled 1 time unit after rising.
    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 1, 4'd7,  1, 1, 0, 4'd0, 0};  // clr beats load and en
        tv[1]  = '{0, 1, 4'd14, 0, 1, 0, 4'd9, 0};  // load clamps to MAX_VAL
        tv[2]  = '{0, 1, 4'd3,  1, 1, 1, 4'd3, 0};  // load beats en at term
        tv[3]  = '{0, 0, 4'd0,  1, 1, 0, 4'd4, 0};
        tv[4]  = '{0, 0, 4'd0,  0, 1, 0, 4'd4, 0};  // hold
        tv[5]  = '{0, 0, 4'd0,  1, 0, 0, 4'd3, 0};  // direction change same edge
        tv[6]  = '{0, 1, 4'd0,  0, 0, 0, 4'd0, 0};
        tv[7]  = '{0, 0, 4'd0,  1, 0, 1, SAT ? 4'd0 : 4'd9, 1};
        tv[8]  = '{0, 0, 4'd0,  0, 0, 0, SAT ? 4'd0 : 4'd9, 0};
        tv[9]  = '{1, 1, 4'd15, 0, 0, 0, 4'd0, 0};
        tv[10] = '{0, 1, 4'd9,  0, 1, 0, 4'd9, 0};
        tv[11] = '{0, 1, 4'd15, 1, 0, 0, 4'd9, 0};  // clamp, tc=0 since count=9 down

        rst_n = 1'b0;
        c_en  = 1'b0;
        drive(0, 0, 4'd0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_wrap", wrap, 0);
        chk("reset_tc", tc, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven priority / clamp / direction checks
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tv[i].clr, tv[i].load, tv[i].lv, tv[i].en, tv[i].up);
            #1;
            chk($sformatf("vec%0d_tc", i), tc, tv[i].etc);
            edge_wait();
            chk($sformatf("vec%0d_count", i), count, tv[i].ecnt);
            chk($sformatf("vec%0d_wrap", i), wrap, tv[i].ewrap);
        end

        // Up run from 0 through the terminal value
        @(negedge clk);
        drive(1, 0, 4'd0, 0, 1);
        edge_wait();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 0, 4'd0, 1, 1);
            #1;
            chk($sformatf("up%0d_tc", i), tc, (i == 9) ? 1 : 0);
            edge_wait();
            chk($sformatf("up%0d_count", i), count, (i == 9) ? (SAT ? 9 : 0) : i + 1);
            chk($sformatf("up%0d_wrap", i), wrap, (i == 9) ? 1 : 0);
        end

        // Down run from 0
        @(negedge clk);
        drive(0, 1, 4'd0, 0, 0);
        edge_wait();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, 0, 4'd0, 1, 0);
            #1;
            chk($sformatf("dn%0d_tc", i), tc, (SAT || i == 0) ? 1 : 0);
            edge_wait();
            chk($sformatf("dn%0d_count", i), count, SAT ? 0 : 9 - i);
            chk($sformatf("dn%0d_wrap", i), wrap, (SAT || i == 0) ? 1 : 0);
        end

        // Repeated up attempts at MAX_VAL
        @(negedge clk);
        drive(0, 1, 4'd9, 0, 1);
        edge_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, 4'd0, 1, 1);
            edge_wait();
            chk($sformatf("top%0d_count", i), count, SAT ? 9 : i);
            chk($sformatf("top%0d_wrap", i), wrap, (SAT || i == 0) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a cycle, wrap pulse pending
        @(negedge clk);
        drive(0, 1, 4'd9, 0, 1);
        edge_wait();
        @(negedge clk);
        drive(0, 0, 4'd0, 1, 1);
        edge_wait();
        chk("pre_rst_wrap", wrap, 1);
        @(negedge clk);
        drive(0, 1, 4'd4, 0, 1);
        edge_wait();
        @(negedge clk);
        drive(0, 0, 4'd0, 1, 1);
        edge_wait();
        chk("pre_rst_count", count, 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wrap", wrap, 0);
        @(negedge clk);
        drive(0, 0, 4'd0, 0, 1);
        rst_n = 1'b1;
        edge_wait();
        chk("post_rst_count", count, 0);

`ifndef UPDOWN_CNT_SAT_EN
        // Mod-60 cascade: upper digit advances only on the lower 9->0 step
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            c_en = 1'b1;
            #1;
            chk($sformatf("casc%0d_lotc", k), lo_tc, (k % 10 == 9) ? 1 : 0);
            edge_wait();
            chk($sformatf("casc%0d_pair", k), hi_count * 10 + lo_count, (k + 1) % 60);
        end
        chk("casc_hi_wrap", hi_wrap, 1);
        @(negedge clk);
        c_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
